// File: rtl/display_pkg.sv
// Shared display definitions: channel indices, pixel slice offsets, frame sizing and
// the frame buffer fill/swap state encoding.
package display_pkg;

  localparam int unsigned CH_RED   = 0;
  localparam int unsigned CH_GREEN = 1;
  localparam int unsigned CH_BLUE  = 2;

  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_PENDING = 1'b1
  } fb_state_e;

  // Bit offset of one colour channel of one segment inside a packed pixel bus.
  function automatic int unsigned pixel_offset(input int unsigned segment,
                                               input int unsigned channel,
                                               input int unsigned bitwidth);
    return (3 * bitwidth * segment) + (bitwidth * channel);
  endfunction

  function automatic int unsigned frame_size(input int unsigned segments,
                                             input int unsigned rows,
                                             input int unsigned columns);
    return segments * rows * columns;
  endfunction

  function automatic int unsigned frame_addr_w(input int unsigned segments,
                                               input int unsigned rows,
                                               input int unsigned columns);
    return (frame_size(segments, rows, columns) > 1) ?
           $clog2(frame_size(segments, rows, columns)) : 1;
  endfunction

endpackage

// File: rtl/framebuffer_bank.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// The read register has a synchronous reset; the array itself is never cleared.
module framebuffer_bank #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WIDTH  = 24
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/display_frame_buffer.sv
// Double-buffered pixel store: raster-order fill into the back bank, swap on frame_complete.
// Optional FB_TEST_PATTERN_EN shows a generated pattern until the first swap after reset.
module display_frame_buffer
  import display_pkg::*;
#(
  parameter int unsigned SEGMENTS = 1,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLUMNS  = 32,
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic                             wr_sof,
  input  logic [3*BITWIDTH-1:0]            wr_data,
  input  logic [$clog2(ROWS)-1:0]          row,
  input  logic [$clog2(COLUMNS)-1:0]       column,
  input  logic                             frame_complete,
  output logic [3*BITWIDTH*SEGMENTS-1:0]   pixel,
  output logic                             frame_pending,
  output logic                             frame_swapped,
  output logic                             front_bank
);

  localparam int unsigned PIX_W    = 3 * BITWIDTH;
  localparam int unsigned ROW_W    = $clog2(ROWS);
  localparam int unsigned COL_W    = $clog2(COLUMNS);
  localparam int unsigned LOC_W    = ROW_W + COL_W;
  localparam int unsigned IDX_W    = frame_addr_w(SEGMENTS, ROWS, COLUMNS);
  localparam int unsigned SEG_W    = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;
  localparam int unsigned LAST_IDX = frame_size(SEGMENTS, ROWS, COLUMNS) - 1;

  fb_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             front_bank_q, front_bank_d;
  logic             frame_pending_q, frame_pending_d;
  logic             frame_swapped_q, frame_swapped_d;
  logic             wr_ready_q, wr_ready_d;

  logic                      accept_c;
  logic [IDX_W-1:0]          wr_idx_c;
  logic [LOC_W-1:0]          wr_loc_c;
  logic [SEG_W-1:0]          wr_seg_c;
  logic [PIX_W*SEGMENTS-1:0] ram_pixel;

  assign accept_c = wr_valid && wr_ready_q;
  // A start-of-frame beat always lands at index 0, abandoning any partial fill.
  assign wr_idx_c = wr_sof ? '0 : idx_q;
  assign wr_loc_c = wr_idx_c[LOC_W-1:0];

  if (SEGMENTS > 1) begin : g_seg_sel
    assign wr_seg_c = wr_idx_c[IDX_W-1:LOC_W];
  end else begin : g_single_seg
    assign wr_seg_c = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_FILL;
      idx_q           <= '0;
      front_bank_q    <= 1'b0;
      frame_pending_q <= 1'b0;
      frame_swapped_q <= 1'b0;
      wr_ready_q      <= 1'b1;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      front_bank_q    <= front_bank_d;
      frame_pending_q <= frame_pending_d;
      frame_swapped_q <= frame_swapped_d;
      wr_ready_q      <= wr_ready_d;
    end
  end

  // Fill/swap sequencing; frame_complete is only honoured once a full frame is held.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    front_bank_d    = front_bank_q;
    frame_pending_d = frame_pending_q;
    frame_swapped_d = 1'b0;
    wr_ready_d      = wr_ready_q;
    unique case (state_q)
      ST_FILL: begin
        if (accept_c) begin
          if (wr_idx_c == IDX_W'(LAST_IDX)) begin
            state_d         = ST_PENDING;
            idx_d           = '0;
            frame_pending_d = 1'b1;
            wr_ready_d      = 1'b0;
          end else begin
            idx_d = wr_idx_c + IDX_W'(1);
          end
        end
      end
      ST_PENDING: begin
        if (frame_complete) begin
          state_d         = ST_FILL;
          front_bank_d    = ~front_bank_q;
          frame_pending_d = 1'b0;
          frame_swapped_d = 1'b1;
          wr_ready_d      = 1'b1;
        end
      end
    endcase
  end

  for (genvar s = 0; s < SEGMENTS; s++) begin : g_bank
    framebuffer_bank #(
      .ADDR_W (LOC_W + 1),
      .WIDTH  (PIX_W)
    ) u_bank (
      .clk     (clk),
      .rst_i   (rst),
      .we_i    (accept_c && (wr_seg_c == SEG_W'(s))),
      .waddr_i ({~front_bank_q, wr_loc_c}),
      .wdata_i (wr_data),
      .raddr_i ({front_bank_q, row, column}),
      .rdata_o (ram_pixel[pixel_offset(s, CH_RED, BITWIDTH) +: PIX_W])
    );
  end

`ifdef FB_TEST_PATTERN_EN
  logic                      pattern_on_q;
  logic                      pattern_sel_q;
  logic [PIX_W*SEGMENTS-1:0] pattern_q, pattern_d;

  always_comb begin
    pattern_d = '0;
    for (int unsigned s = 0; s < SEGMENTS; s++) begin
      pattern_d[pixel_offset(s, CH_RED,   BITWIDTH) +: BITWIDTH] = BITWIDTH'(column);
      pattern_d[pixel_offset(s, CH_GREEN, BITWIDTH) +: BITWIDTH] = BITWIDTH'(row);
      pattern_d[pixel_offset(s, CH_BLUE,  BITWIDTH) +: BITWIDTH] = BITWIDTH'(s);
    end
  end

  // Pattern tracks the RAM read latency so the switch-over is address-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_on_q  <= 1'b1;
      pattern_sel_q <= 1'b0;
      pattern_q     <= '0;
    end else begin
      if (frame_swapped_d) begin
        pattern_on_q <= 1'b0;
      end
      pattern_sel_q <= pattern_on_q;
      pattern_q     <= pattern_d;
    end
  end

  assign pixel = pattern_sel_q ? pattern_q : ram_pixel;
`else
  assign pixel = ram_pixel;
`endif

  assign wr_ready      = wr_ready_q;
  assign frame_pending = frame_pending_q;
  assign frame_swapped = frame_swapped_q;
  assign front_bank    = front_bank_q;

endmodule
